// File: rtl/led_scan_driver.sv
// Row-multiplexed LED matrix driver for the 16x16 cell board: snapshots the live
// frame at frame boundaries, scans it out row by row, and emits frame/step pulses.
module led_scan_driver #(
    parameter int SCAN_DIV     = 1024,
    parameter int BLANK_CYCLES = 64,
    parameter int STEP_FRAMES  = 30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [15:0][15:0] pixels,
    output logic [15:0]       row_out,
    output logic [15:0]       col_out,
    output logic              frame_tick,
    output logic              step
);

    localparam int            CW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [7:0]    FCNT_LAST = 8'(STEP_FRAMES - 1);

    logic [3:0]        row_q, row_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [15:0][15:0] disp_buf_q, disp_buf_d;
    logic [7:0]        fcnt_q, fcnt_d;
    logic              frame_tick_q, frame_tick_d;
    logic              step_q, step_d;
    logic              blank_s;
    logic              frame_end_s;

    function automatic logic [15:0] row_onehot(input logic [3:0] r);
        return 16'd1 << r;
    endfunction

    // A zero-length blanking window never darkens a slot.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign blank_s = 1'b0;
        end else begin : g_blank
            localparam logic [CW-1:0] BLANK_W = CW'(BLANK_CYCLES);
            assign blank_s = (cnt_q < BLANK_W);
        end
    endgenerate

    assign frame_end_s = (row_q == 4'd15) && (cnt_q == CNT_LAST);

    // Next-state logic for the scan position, display buffer and frame counters.
    always_comb begin
        row_d        = row_q;
        cnt_d        = cnt_q;
        disp_buf_d   = disp_buf_q;
        fcnt_d       = fcnt_q;
        frame_tick_d = 1'b0;
        step_d       = 1'b0;
        if (!enable) begin
            // Idle: park at row 0 and keep the buffer following the board.
            row_d      = 4'd0;
            cnt_d      = '0;
            disp_buf_d = pixels;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            row_d = row_q + 4'd1;
            if (frame_end_s) begin
                disp_buf_d   = pixels;
                frame_tick_d = 1'b1;
                if (fcnt_q == FCNT_LAST) begin
                    fcnt_d = 8'd0;
                    step_d = 1'b1;
                end else begin
                    fcnt_d = fcnt_q + 8'd1;
                end
            end else begin
                disp_buf_d = disp_buf_q;
            end
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q        <= 4'd0;
            cnt_q        <= '0;
            disp_buf_q   <= '0;
            fcnt_q       <= 8'd0;
            frame_tick_q <= 1'b0;
            step_q       <= 1'b0;
        end else begin
            row_q        <= row_d;
            cnt_q        <= cnt_d;
            disp_buf_q   <= disp_buf_d;
            fcnt_q       <= fcnt_d;
            frame_tick_q <= frame_tick_d;
            step_q       <= step_d;
        end
    end

    // Matrix drive decoded from registered state; dark while idle, blanking or in reset.
    always_comb begin
        row_out = 16'd0;
        col_out = 16'd0;
        if (reset && enable && !blank_s) begin
            row_out = row_onehot(row_q);
            col_out = disp_buf_q[row_q];
        end else begin
            row_out = 16'd0;
            col_out = 16'd0;
        end
    end

    assign frame_tick = frame_tick_q;
    assign step       = step_q;

endmodule

// File: tb/tb_led_scan_driver.sv
// Directed bench for led_scan_driver: a flat-position frame model checked every
// cycle on two configurations, plus hand-computed checkpoints.
module tb_led_scan_driver;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic [15:0][15:0] pixels;
    logic [15:0]       row_out1, col_out1, row_out2, col_out2;
    logic              ft1, st1, ft2, st2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_scan_driver #(.SCAN_DIV(8), .BLANK_CYCLES(2), .STEP_FRAMES(3)) dut1 (
        .clk(clk), .reset(rst_n), .enable(enable), .pixels(pixels),
        .row_out(row_out1), .col_out(col_out1), .frame_tick(ft1), .step(st1)
    );

    led_scan_driver #(.SCAN_DIV(2), .BLANK_CYCLES(0), .STEP_FRAMES(1)) dut2 (
        .clk(clk), .reset(rst_n), .enable(enable), .pixels(pixels),
        .row_out(row_out2), .col_out(col_out2), .frame_tick(ft2), .step(st2)
    );

    function automatic int sd(input int k);
        return (k == 0) ? 8 : 2;
    endfunction
    function automatic int bl(input int k);
        return (k == 0) ? 2 : 0;
    endfunction
    function automatic int sf(input int k);
        return (k == 0) ? 3 : 1;
    endfunction

    // Model: position within the frame as one number, rows of the shown frame, frames done.
    int                m_pos[2];
    int                m_frames[2];
    logic [15:0][15:0] m_shown[2];
    logic              m_tick[2];
    logic              m_step[2];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_pos[k] <= 0; m_frames[k] <= 0; m_shown[k] <= '0;
                m_tick[k] <= 1'b0; m_step[k] <= 1'b0;
            end else if (!enable) begin
                m_pos[k] <= 0; m_shown[k] <= pixels;
                m_tick[k] <= 1'b0; m_step[k] <= 1'b0;
            end else if (m_pos[k] == 16 * sd(k) - 1) begin
                m_pos[k]    <= 0;
                m_shown[k]  <= pixels;
                m_frames[k] <= m_frames[k] + 1;
                m_tick[k]   <= 1'b1;
                m_step[k]   <= (((m_frames[k] + 1) % sf(k)) == 0);
            end else begin
                m_pos[k] <= m_pos[k] + 1;
                m_tick[k] <= 1'b0; m_step[k] <= 1'b0;
            end
        end
    end

    function automatic logic lit(input int k);
        return rst_n && enable && ((m_pos[k] % sd(k)) >= bl(k));
    endfunction
    function automatic logic [15:0] exp_row(input int k);
        return lit(k) ? (16'd1 << (m_pos[k] / sd(k))) : 16'd0;
    endfunction
    function automatic logic [15:0] exp_col(input int k);
        return lit(k) ? m_shown[k][m_pos[k] / sd(k)] : 16'd0;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        check("row_out1", row_out1, exp_row(0));
        check("col_out1", col_out1, exp_col(0));
        check("frame_tick1", {15'd0, ft1}, {15'd0, m_tick[0]});
        check("step1", {15'd0, st1}, {15'd0, m_step[0]});
        check("row_out2", row_out2, exp_row(1));
        check("col_out2", col_out2, exp_col(1));
        check("frame_tick2", {15'd0, ft2}, {15'd0, m_tick[1]});
        check("step2", {15'd0, st2}, {15'd0, m_step[1]});
    end

    int e;
    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
        e += n;
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        pixels = '1;
        e      = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_row1", row_out1, 16'h0000);
        check("reset_col1", col_out1, 16'h0000);
        check("reset_tick1", {15'd0, ft1}, 16'h0000);
        check("reset_step1", {15'd0, st1}, 16'h0000);
        check("reset_row2", row_out2, 16'h0000);

        // Scan-order pattern, loaded while idle.
        for (int i = 0; i < 16; i++) pixels[i] = 16'h0001 << i;
        enable = 1'b0;
        rst_n  = 1'b1;
        adv(2);
        enable = 1'b1;
        e = 0;
        adv(1);
        check("blank_e1_row1", row_out1, 16'h0000);
        check("bnd_e1_row2", row_out2, 16'h0001);
        check("bnd_e1_col2", col_out2, 16'h0001);
        adv(1);
        check("scan_e2_row1", row_out1, 16'h0001);
        check("scan_e2_col1", col_out1, 16'h0001);
        check("bnd_e2_row2", row_out2, 16'h0002);
        check("bnd_e2_col2", col_out2, 16'h0002);
        adv(30);
        check("bnd_e32_tick2", {15'd0, ft2}, 16'h0001);
        check("bnd_e32_step2", {15'd0, st2}, 16'h0001);

        // Tearing: board cleared mid-frame must not reach the display this frame.
        adv(8);
        pixels = '0;
        adv(3);
        check("tear_e43_row1", row_out1, 16'h0020);
        check("tear_e43_col1", col_out1, 16'h0020);
        adv(84);
        check("tear_e127_col1", col_out1, 16'h8000);
        adv(1);
        check("tick_e128", {15'd0, ft1}, 16'h0001);
        check("step_e128", {15'd0, st1}, 16'h0000);
        check("dark_e128_row1", row_out1, 16'h0000);
        adv(1);
        check("tick_e129", {15'd0, ft1}, 16'h0000);
        adv(1);
        check("tear_e130_row1", row_out1, 16'h0001);
        check("tear_e130_col1", col_out1, 16'h0000);
        for (int i = 0; i < 16; i++) pixels[i] = 16'(i) * 16'h0101;
        adv(126);
        check("tick_e256", {15'd0, ft1}, 16'h0001);
        check("step_e256", {15'd0, st1}, 16'h0000);
        adv(128);
        check("tick_e384", {15'd0, ft1}, 16'h0001);
        check("step_e384", {15'd0, st1}, 16'h0001);
        adv(1);
        check("step_e385", {15'd0, st1}, 16'h0000);

        // Enable drop at row 7, cnt 4.
        adv(59);
        enable = 1'b0;
        #1;
        check("drop_row1", row_out1, 16'h0000);
        check("drop_col1", col_out1, 16'h0000);
        adv(2);
        for (int i = 0; i < 16; i++) pixels[i] = 16'h1234 + 16'(i);
        adv(3);
        check("drop_tick1", {15'd0, ft1}, 16'h0000);
        enable = 1'b1;
        pixels = '1;
        e = 0;
        adv(1);
        check("restart_e1_row1", row_out1, 16'h0000);
        adv(1);
        check("restart_e2_row1", row_out1, 16'h0001);
        check("restart_e2_col1", col_out1, 16'h1234);
        adv(126);
        check("restart_tick128", {15'd0, ft1}, 16'h0001);
        check("restart_step128", {15'd0, st1}, 16'h0000);
        adv(128);
        check("restart_step256", {15'd0, st1}, 16'h0000);
        adv(128);
        check("restart_tick384", {15'd0, ft1}, 16'h0001);
        check("restart_step384", {15'd0, st1}, 16'h0001);

        // Asynchronous reset mid-row.
        adv(3);
        check("prereset_row1", row_out1, 16'h0001);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_row1", row_out1, 16'h0000);
        check("midreset_col1", col_out1, 16'h0000);
        check("midreset_row2", row_out2, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_scan_driver.md
# led_scan_driver

Downstream consumer of the 16x16 cell board: snapshots the live `pixels` frame into a display buffer at frame boundaries and row-multiplexes it onto a 16x16 LED matrix. Each row gets one slot, with a blanking interval at the start of the slot. The block also produces a per-frame tick and a generation-step pulse, which the board control uses to advance the simulation in sync with whole displayed frames. Advancing only between frames prevents tearing.

## Interface
- `SCAN_DIV`, 1024, clock cycles per row slot; legal range 2..65536.
- `BLANK_CYCLES`, 64, cycles at the start of each slot with the matrix dark; 0 ≤ BLANK_CYCLES < SCAN_DIV.
- `STEP_FRAMES`, 30, displayed frames per `step` pulse; legal range 1..256.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  1 = scan running; 0 = scan held and display dark.
- `pixels`  in  [15:0][15:0]  live board; `pixels[i][j]` is row i, column j, 1 = alive.
- `row_out`  out  16  one-hot row drive, active-high; bit i = row i.
- `col_out`  out  16  column data for the driven row, active-high; bit j = `buf[i][j]`.
- `frame_tick`  out  1  one-cycle pulse after each completed frame.
- `step`  out  1  one-cycle pulse every `STEP_FRAMES` completed frames.

## Operation
- State registers:
  - `row` (4 b)
  - `cnt` (ceil(log2(SCAN_DIV)) b)
  - `buf` (16x16)
  - `fcnt` (8 b)
  - `frame_tick`, `step`
- `row_out`/`col_out` are combinational decodes of registered state only:
  - If `enable`=0 or `cnt` < BLANK_CYCLES: `row_out`=0 and `col_out`=0.
  - Otherwise: `row_out` = 1<<`row` and `col_out` = `buf[row]`.
- `enable`=0 at an edge:
  - `row`←0, `cnt`←0, `frame_tick`←0, `step`←0; `fcnt` holds.
  - `buf`←`pixels`, so `buf` tracks the board while idle.
- `enable`=1 at an edge:
  - `cnt` increments; at SCAN_DIV-1 it wraps to 0 and `row` increments.
  - `row` wraps 15→0.
- End-of-frame edge (`enable`=1, `row`=15, `cnt`=SCAN_DIV-1):
  - `buf`←`pixels`. This is the only mid-run snapshot; `pixels` changes inside a frame are invisible until the next frame.
  - `frame_tick`←1.
  - If `fcnt`=STEP_FRAMES-1: `fcnt`←0 and `step`←1. Otherwise `fcnt`←`fcnt`+1.
- Every other edge: `frame_tick`←0, `step`←0.
- `step` is high only in a cycle where `frame_tick` is also high.
- Frame period while enabled: 16·SCAN_DIV cycles. `step` period: 16·SCAN_DIV·STEP_FRAMES cycles.
- Mid-frame `enable` drop:
  - Outputs go dark immediately (combinational).
  - The counters return to row 0, slot 0 at the next edge.
  - The partial frame produces no `frame_tick` and is not counted in `fcnt`.

## Timing
- Reset asserted (`reset`=0), asynchronously:
  - `row`=0, `cnt`=0, `buf`=0, `fcnt`=0.
  - `frame_tick`=0, `step`=0, `row_out`=0, `col_out`=0.
- Reset release: state holds until the first `clk` edge. With `enable`=1 at that edge, `cnt` becomes 1.
- Row slot layout:
  - Row r is lit (nonzero outputs) for exactly SCAN_DIV−BLANK_CYCLES cycles per frame.
  - It is dark for the BLANK_CYCLES cycles preceding that window.
  - With BLANK_CYCLES=0, rows switch back to back with no dark gap.
- Snapshot latency: a `pixels` value sampled at the end-of-frame edge appears on `col_out` at the first lit cycle of row 0, i.e. BLANK_CYCLES cycles after that edge.
- `frame_tick` and `step` are registered. They are high in the cycle where `row`=0, `cnt`=0 following a wrap.
- `enable` and `pixels` are synchronous to `clk`. Synchronising external sources is the upstream block's responsibility.

## Test plan
Parameters for all scenarios: SCAN_DIV=8, BLANK_CYCLES=2, STEP_FRAMES=3.

- **Reset:** hold `reset`=0 with `enable`=1 and `pixels`=all-ones → `row_out`=0, `col_out`=0, `frame_tick`=0, `step`=0. Asserting `reset` low mid-row forces the outputs to 0 before the next edge.
- **Scan order:**
  - Stimulus: `pixels[i]`=16'h0001<<i; `enable` 0→1.
  - Response: per 8-cycle slot, 2 dark cycles, then 6 cycles of `row_out`=`col_out`=16'h0001<<i, for i=0..15 in order, then repeating.
- **Tearing:** change `pixels` to all-zeros at cycle 40 of a frame → rows 5..15 of that frame still show the old data. All-zero columns first appear at cycle 2 of the next frame.
- **Ticks:**
  - Stimulus: `enable` held high for 400 cycles.
  - `frame_tick` pulses are exactly 1 cycle wide, at cycles 128, 256 and 384.
  - `step` pulses only at cycle 384, then every 384 cycles.
- **Enable drop:**
  - Stimulus: deassert `enable` at row 7, `cnt` 4; reassert 5 cycles later.
  - Response: outputs 0 while `enable`=0; no `frame_tick`; `fcnt` unchanged.
  - The scan restarts at row 0 with 2 dark cycles and shows `pixels` as sampled at the last `enable`=0 edge.
- **Boundary:** BLANK_CYCLES=0, SCAN_DIV=2 → no dark cycles while enabled. `row_out` is one-hot on every enabled cycle and advances every 2 cycles.
